// File: rtl/fpu_cmp_pipe.sv
// Pipelined floating-point compare/sign/class unit (fclass, fmin/fmax, fsgnj*, flt/fle/feq).
// All arithmetic sits in front of stage 1; the remaining stages are a stall-able delay line.
module fpu_cmp_pipe #(
    parameter  int EXP_W  = 8,
    parameter  int MAN_W  = 23,
    parameter  int STAGES = 2,
    parameter  int TAG_W  = 5,
    localparam int FLEN   = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_op,
    input  logic [FLEN-1:0]  in_rs1,
    input  logic [FLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       out_fflags,
    output logic [4:0]       fflags_sticky,
    input  logic             fflags_clr
);
    localparam logic [5:0] OP_FCLASS = 6'd8;
    localparam logic [5:0] OP_FMIN   = 6'd9;
    localparam logic [5:0] OP_FMAX   = 6'd10;
    localparam logic [5:0] OP_FSGNJ  = 6'd11;
    localparam logic [5:0] OP_FSGNJN = 6'd12;
    localparam logic [5:0] OP_FSGNJX = 6'd13;
    localparam logic [5:0] OP_FLT    = 6'd14;
    localparam logic [5:0] OP_FLE    = 6'd15;
    localparam logic [5:0] OP_FEQ    = 6'd16;

    localparam logic [FLEN-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic [FLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
        logic [4:0]       flg;
    } stage_t;

    typedef struct packed {
        logic nan;
        logic snan;
        logic zero;
    } cls_t;

    function automatic cls_t classify(input logic [FLEN-1:0] x);
        cls_t c;
        logic e_ones, e_zero, m_zero;
        e_ones = &x[FLEN-2:MAN_W];
        e_zero = ~|x[FLEN-2:MAN_W];
        m_zero = ~|x[MAN_W-1:0];
        c.nan  = e_ones & ~m_zero;
        c.snan = e_ones & ~m_zero & ~x[MAN_W-1];
        c.zero = e_zero & m_zero;
        return c;
    endfunction

    logic [STAGES-1:0] vld_q;
    stage_t [STAGES-1:0] stg_q;
    stage_t stage_d;
    logic [4:0] sticky_q, sticky_d;
    logic en;

    cls_t c1, c2;
    logic any_nan, any_snan, both_zero, eq, ord_lt;
    logic s1, e1_ones, e1_zero, m1_zero;
    logic [9:0] cls_vec;

    assign out_valid = vld_q[STAGES-1];
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

    always_comb begin
        c1        = classify(in_rs1);
        c2        = classify(in_rs2);
        any_nan   = c1.nan | c2.nan;
        any_snan  = c1.snan | c2.snan;
        both_zero = c1.zero & c2.zero;
        eq        = (in_rs1 == in_rs2) | both_zero;
        // Sign-magnitude total order with -0 below +0; callers mask the zero case where needed.
        if (in_rs1[FLEN-1] != in_rs2[FLEN-1])
            ord_lt = in_rs1[FLEN-1];
        else if (in_rs1[FLEN-1])
            ord_lt = in_rs1[FLEN-2:0] > in_rs2[FLEN-2:0];
        else
            ord_lt = in_rs1[FLEN-2:0] < in_rs2[FLEN-2:0];

        s1      = in_rs1[FLEN-1];
        e1_ones = &in_rs1[FLEN-2:MAN_W];
        e1_zero = ~|in_rs1[FLEN-2:MAN_W];
        m1_zero = ~|in_rs1[MAN_W-1:0];
        cls_vec = {c1.nan & ~c1.snan, c1.snan,
                   ~s1 & e1_ones & m1_zero, ~s1 & ~e1_ones & ~e1_zero,
                   ~s1 & e1_zero & ~m1_zero, ~s1 & c1.zero,
                   s1 & c1.zero, s1 & e1_zero & ~m1_zero,
                   s1 & ~e1_ones & ~e1_zero, s1 & e1_ones & m1_zero};

        stage_d     = '0;
        stage_d.tag = in_tag;
        case (in_op)
            OP_FCLASS: stage_d.res[9:0] = cls_vec;
            OP_FMIN, OP_FMAX: begin
                stage_d.flg[4] = any_snan;
                if (c1.nan && c2.nan)
                    stage_d.res = CANON_NAN;
                else if (c1.nan)
                    stage_d.res = in_rs2;
                else if (c2.nan)
                    stage_d.res = in_rs1;
                else
                    stage_d.res = ((in_op == OP_FMIN) == ord_lt) ? in_rs1 : in_rs2;
            end
            OP_FSGNJ:  stage_d.res = {in_rs2[FLEN-1], in_rs1[FLEN-2:0]};
            OP_FSGNJN: stage_d.res = {~in_rs2[FLEN-1], in_rs1[FLEN-2:0]};
            OP_FSGNJX: stage_d.res = {in_rs1[FLEN-1] ^ in_rs2[FLEN-1], in_rs1[FLEN-2:0]};
            OP_FLT: begin
                stage_d.flg[4] = any_nan;
                stage_d.res[0] = ~any_nan & ~both_zero & ord_lt;
            end
            OP_FLE: begin
                stage_d.flg[4] = any_nan;
                stage_d.res[0] = ~any_nan & (ord_lt | eq);
            end
            OP_FEQ: begin
                stage_d.flg[4] = any_snan;
                stage_d.res[0] = ~any_nan & eq;
            end
            default: ;
        endcase
        // Bubbles carry zeros so the output registers never show stale data.
        if (!in_valid)
            stage_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            stg_q <= '0;
        end else if (en) begin
            vld_q[0] <= in_valid;
            stg_q[0] <= stage_d;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                stg_q[i] <= stg_q[i-1];
            end
        end
    end

    assign sticky_d = (fflags_clr ? 5'b0 : sticky_q)
                    | ((out_valid && out_ready) ? stg_q[STAGES-1].flg : 5'b0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sticky_q <= '0;
        else
            sticky_q <= sticky_d;
    end

    assign out_result    = stg_q[STAGES-1].res;
    assign out_tag       = stg_q[STAGES-1].tag;
    assign out_fflags    = stg_q[STAGES-1].flg;
    assign fflags_sticky = sticky_q;
endmodule

// File: tb/tb_fpu_cmp_pipe.sv
// Randomised + directed bench for fpu_cmp_pipe (binary32, 2 stages) against a real-valued model.
module tb_fpu_cmp_pipe;
    localparam int STAGES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [31:0] in_rs1, in_rs2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic [4:0]  out_fflags;
    logic [4:0]  fflags_sticky;
    logic        fflags_clr;

    fpu_cmp_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(STAGES), .TAG_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_fflags(out_fflags),
        .fflags_sticky(fflags_sticky), .fflags_clr(fflags_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic [4:0]  flg;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0, n_fail = 0;
    logic [4:0]  sticky_m = '0;
    logic        held = 1'b0;
    logic [31:0] h_res;
    logic [4:0]  h_tag, h_flg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] != 0;
    endfunction

    function automatic real fval(input logic [31:0] x);
        real m;
        int  e;
        e = int'(x[30:23]);
        if (e == 255)    m = 1.0e300;
        else if (e == 0) m = real'(x[22:0]) * 2.0 ** (-149);
        else             m = (1.0 + real'(x[22:0]) / 8388608.0) * 2.0 ** (e - 127);
        return x[31] ? -m : m;
    endfunction

    task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [4:0] f);
        bit  an, bn, as, bs;
        real va, vb;
        int  idx;
        an = is_nan(a); bn = is_nan(b);
        as = an && !a[22]; bs = bn && !b[22];
        va = fval(a); vb = fval(b);
        r = '0; f = '0;
        case (op)
            6'd8: begin
                if (an)                         idx = as ? 8 : 9;
                else if (a[30:23] == 8'hFF)     idx = a[31] ? 0 : 7;
                else if (a[30:0] == 0)          idx = a[31] ? 3 : 4;
                else if (a[30:23] == 0)         idx = a[31] ? 2 : 5;
                else                            idx = a[31] ? 1 : 6;
                r = 32'd1 << idx;
            end
            6'd9, 6'd10: begin
                if (as || bs) f = 5'h10;
                if (an && bn)      r = 32'h7FC00000;
                else if (an)       r = b;
                else if (bn)       r = a;
                else if (va == vb) r = ((op == 6'd9) == a[31]) ? a : b;
                else if (op == 6'd9) r = (va < vb) ? a : b;
                else                 r = (va > vb) ? a : b;
            end
            6'd11: r = {b[31], a[30:0]};
            6'd12: r = {~b[31], a[30:0]};
            6'd13: r = {a[31] ^ b[31], a[30:0]};
            6'd14: if (an || bn) f = 5'h10; else r = {31'd0, va < vb};
            6'd15: if (an || bn) f = 5'h10; else r = {31'd0, va <= vb};
            6'd16: begin
                if (as || bs) f = 5'h10;
                if (!an && !bn) r = {31'd0, va == vb};
            end
            default: ;
        endcase
    endtask

    // One clock: entered just after a negedge with inputs set, leaves at the next negedge.
    task automatic step(output logic acc);
        logic pop;
        exp_t e;
        logic [4:0] pf;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, !out_valid || out_ready});
        if (held) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_result", out_result, h_res);
            chk("stall_tag", {27'd0, out_tag}, {27'd0, h_tag});
            chk("stall_flags", {27'd0, out_fflags}, {27'd0, h_flg});
        end
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        pf  = '0;
        if (pop) begin
            if (sb.size() == 0) chk("spurious_result", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                pf = e.flg;
                chk("result", out_result, e.res);
                chk("tag", {27'd0, out_tag}, {27'd0, e.tag});
                chk("flags", {27'd0, out_fflags}, {27'd0, e.flg});
            end
        end
        if (acc) begin
            model(in_op, in_rs1, in_rs2, e.res, e.flg);
            e.tag = in_tag;
            sb.push_back(e);
        end
        sticky_m = (fflags_clr ? 5'd0 : sticky_m) | pf;
        held  = out_valid && !out_ready;
        h_res = out_result; h_tag = out_tag; h_flg = out_fflags;
        @(negedge clk);
        chk("sticky", {27'd0, fflags_sticky}, {27'd0, sticky_m});
    endtask

    // Issue one op on an empty pipe, check latency and the value against constants, then drain it.
    task automatic dir(input string nm, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] er, input logic [4:0] ef, input logic clr);
        logic acc;
        int k;
        in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag; out_ready = 1'b1;
        step(acc);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 10) begin
            step(acc);
            k++;
        end
        chk({nm, "_latency"}, k, STAGES - 1);
        chk({nm, "_res"}, out_result, er);
        chk({nm, "_tag"}, {27'd0, out_tag}, {27'd0, tag});
        chk({nm, "_flg"}, {27'd0, out_fflags}, {27'd0, ef});
        fflags_clr = clr;
        step(acc);
        fflags_clr = 1'b0;
    endtask

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] sp[12];
        sp = '{32'h7F800001, 32'h7FC00000, 32'hFFC00001, 32'h7F800000, 32'hFF800000,
               32'h00000000, 32'h80000000, 32'h00000001, 32'h807FFFFF, 32'h3F800000,
               32'hBF800000, 32'h3F800001};
        if ($urandom_range(0, 1) == 0) return sp[$urandom_range(0, 11)];
        return $urandom();
    endfunction

    initial begin
        logic acc;
        logic [5:0]  bp_op[6];
        logic [31:0] bp_a[6], bp_b[6];
        logic [3:0]  pat;
        int issued, got, cyc;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic acc;
        logic [5:0]  bp_op[6];
        logic [31:0] bp_a[6], bp_b[6];
        logic [3:0]  pat;
        int issued, got, cyc;

        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
        out_ready = 1'b1; fflags_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
        chk("rst_out_fflags", {27'd0, out_fflags}, 32'd0);
        chk("rst_sticky", {27'd0, fflags_sticky}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        dir("fmin_zero",  6'd9,  32'h80000000, 32'h00000000, 5'd3, 32'h80000000, 5'h00, 1'b0);
        dir("fmax_qnan",  6'd10, 32'h7FC00000, 32'h3F800000, 5'd4, 32'h3F800000, 5'h00, 1'b0);
        dir("fmin_2nan",  6'd9,  32'h7F800001, 32'hFFC00000, 5'd5, 32'h7FC00000, 5'h10, 1'b0);
        chk("sticky_set", {27'd0, fflags_sticky}, 32'h10);
        dir("flt_snan",   6'd14, 32'h7F800001, 32'h3F800000, 5'd6, 32'h0, 5'h10, 1'b1);
        chk("sticky_clr_and_set", {27'd0, fflags_sticky}, 32'h10);
        fflags_clr = 1'b1;
        step(acc);
        fflags_clr = 1'b0;
        chk("sticky_clr", {27'd0, fflags_sticky}, 32'h00);
        dir("feq_qnan",   6'd16, 32'h7FC00000, 32'h7FC00000, 5'd7, 32'h0, 5'h00, 1'b0);
        dir("fle_zero",   6'd15, 32'h80000000, 32'h00000000, 5'd8, 32'h1, 5'h00, 1'b0);
        dir("fclass_ninf", 6'd8, 32'hFF800000, 32'h0, 5'd9, 32'h001, 5'h00, 1'b0);
        dir("fclass_psub", 6'd8, 32'h00000001, 32'h0, 5'd10, 32'h020, 5'h00, 1'b0);
        dir("fsgnjx",     6'd13, 32'hBF800000, 32'h80000000, 5'd11, 32'h3F800000, 5'h00, 1'b0);
        dir("bad_op",     6'd3,  32'h3F800000, 32'h7F800001, 5'd12, 32'h0, 5'h00, 1'b0);

        // Backpressure: out_ready follows 1,0,0,1 while six tagged ops stream in.
        bp_op = '{6'd9, 6'd10, 6'd14, 6'd8, 6'd11, 6'd16};
        bp_a  = '{32'h3F800000, 32'hBF800000, 32'h7F800001, 32'h807FFFFF, 32'h40000000, 32'h00000000};
        bp_b  = '{32'h40000000, 32'h7FC00000, 32'h00000000, 32'h0, 32'h80000000, 32'h80000000};
        pat = 4'b1001;
        issued = 0; got = 0; cyc = 0;
        while ((issued < 6 || sb.size() > 0) && cyc < 100) begin
            out_ready = pat[cyc % 4];
            in_valid  = issued < 6;
            if (issued < 6) begin
                in_op = bp_op[issued]; in_rs1 = bp_a[issued]; in_rs2 = bp_b[issued];
                in_tag = 5'(16 + issued);
            end
            if (out_valid && out_ready) begin
                chk("bp_order", {27'd0, out_tag}, 32'(16 + got));
                got++;
            end
            step(acc);
            if (acc) issued++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp_count", got, 6);

        // Reset with two operations in flight.
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 6'd10; in_rs1 = 32'h3F800000; in_rs2 = 32'h40000000; in_tag = 5'd1;
        step(acc);
        in_tag = 5'd2;
        step(acc);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_flight_valid", {31'd0, out_valid}, 32'd0);
        sb.delete(); held = 1'b0; sticky_m = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(acc);
            chk("rst_no_stale", {31'd0, out_valid}, 32'd0);
        end

        // Random traffic, source holds each op until accepted.
        for (int i = 0; i < 600; i++) begin
            out_ready  = $urandom_range(0, 3) != 0;
            fflags_clr = $urandom_range(0, 7) == 0;
            if (!in_valid && $urandom_range(0, 9) < 7) begin
                in_valid = 1'b1;
                in_op  = 6'($urandom_range(7, 17));
                in_rs1 = rnd_opnd();
                in_rs2 = rnd_opnd();
                in_tag = 5'($urandom);
            end
            step(acc);
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b1; fflags_clr = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) step(acc);
        chk("drain_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
